adder_rr_scheduler: RTL

//  Shares one LIMB_W-bit parallel adder (e.g. tt_um_parallel_adder, used combinationally) between NREQ requesters.

---
 rtl/adder_sched_pkg.sv | 19 +
 rtl/adder_rr_scheduler_rr_arbiter.sv | 32 +++
 rtl/adder_rr_scheduler.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/adder_sched_pkg.sv
// Shared definitions for the round-robin limb-serial adder scheduler.
package adder_sched_pkg;

  localparam int LIMB_W_DEF = 3;
  localparam int NLIMB_DEF  = 4;
  localparam int OPW_DEF    = LIMB_W_DEF * NLIMB_DEF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Index width for n items; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after 'last', searching cyclically.
module rr_arbiter
  import adder_sched_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IDW = id_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int i = 1; i <= NREQ; i++) begin
      j = int'(last) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/adder_rr_scheduler.sv
// Shares one external LIMB_W-bit adder among NREQ requesters; each add is run limb-serially,
// LSB limb first, and the result is returned on a valid/ready port with a hold watchdog.
module adder_rr_scheduler
  import adder_sched_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int LIMB_W    = LIMB_W_DEF,
  parameter int NLIMB     = NLIMB_DEF,
  parameter int MAX_COUNT = 1000,
  localparam int OPW = NLIMB * LIMB_W,
  localparam int IDW = id_w(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*OPW-1:0]  req_a,
  input  logic [NREQ*OPW-1:0]  req_b,
  input  logic [NREQ-1:0]      req_cin,
  output logic [LIMB_W-1:0]    add_a,
  output logic [LIMB_W-1:0]    add_b,
  output logic                 add_cin,
  input  logic [LIMB_W-1:0]    add_sum,
  input  logic                 add_cout,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [OPW-1:0]       rsp_sum,
  output logic                 rsp_cout,
  output logic                 rsp_drop,
  output logic                 busy
);

  localparam int LW  = id_w(NLIMB);
  localparam int WDW = $clog2(MAX_COUNT + 1);
  localparam logic [LW-1:0]  LAST_LIMB = LW'(NLIMB - 1);
  localparam logic [WDW-1:0] WD_LIMIT  = WDW'(MAX_COUNT);

  state_e          state_q, state_d;
  logic [IDW-1:0]  rr_last_q, rr_last_d;
  logic [LW-1:0]   limb_q, limb_d;
  logic            carry_q, carry_d;
  logic [WDW-1:0]  wd_q, wd_d;
  logic            hold_q;
  logic [OPW-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IDW-1:0]  id_q, id_d;

  logic [NREQ-1:0] arb_gnt;
  logic [IDW-1:0]  arb_idx;
  logic            arb_any;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req  (req_valid),
    .last (rr_last_q),
    .gnt  (arb_gnt),
    .idx  (arb_idx),
    .any  (arb_any)
  );

  // Control state: the only registers that see reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rr_last_q <= IDW'(NREQ - 1);
      limb_q    <= '0;
      carry_q   <= 1'b0;
      wd_q      <= '0;
      hold_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      limb_q    <= limb_d;
      carry_q   <= carry_d;
      wd_q      <= wd_d;
      hold_q    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    sum_q <= sum_d;
    id_q  <= id_d;
  end

  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    limb_d    = limb_q;
    carry_d   = carry_q;
    wd_d      = wd_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    id_d      = id_q;
    req_ready = '0;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    rsp_valid = 1'b0;
    rsp_id    = '0;
    rsp_sum   = '0;
    rsp_cout  = 1'b0;
    rsp_drop  = 1'b0;
    busy      = (state_q != S_IDLE);

    unique case (state_q)
      S_IDLE: begin
        // Grants are held off for one cycle after reset release.
        if (!hold_q && arb_any) begin
          req_ready = arb_gnt;
          a_d       = req_a[arb_idx*OPW +: OPW];
          b_d       = req_b[arb_idx*OPW +: OPW];
          carry_d   = req_cin[arb_idx];
          id_d      = arb_idx;
          rr_last_d = arb_idx;
          limb_d    = '0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        add_a   = a_q[limb_q*LIMB_W +: LIMB_W];
        add_b   = b_q[limb_q*LIMB_W +: LIMB_W];
        add_cin = carry_q;
        sum_d[limb_q*LIMB_W +: LIMB_W] = add_sum;
        carry_d = add_cout;
        if (limb_q == LAST_LIMB) begin
          limb_d  = '0;
          wd_d    = '0;
          state_d = S_DONE;
        end else begin
          limb_d = limb_q + 1'b1;
        end
      end
      S_DONE: begin
        if (wd_q == WD_LIMIT) begin
          rsp_drop = 1'b1;
          state_d  = S_IDLE;
        end else begin
          rsp_valid = 1'b1;
          rsp_id    = id_q;
          rsp_sum   = sum_q;
          rsp_cout  = carry_q;
          if (rsp_ready) state_d = S_IDLE;
          else           wd_d    = wd_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are forced quiet for the whole reset cycle, whatever state is held.
    if (rst) begin
      req_ready = '0;
      add_a     = '0;
      add_b     = '0;
      add_cin   = 1'b0;
      rsp_valid = 1'b0;
      rsp_id    = '0;
      rsp_sum   = '0;
      rsp_cout  = 1'b0;
      rsp_drop  = 1'b0;
      busy      = 1'b0;
    end
  end

endmodule
